// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op encodings, FSM state encoding and default width for alu_seq
package alu_seq_pkg;

  localparam int ALU_SEQ_W = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } logic_op_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NEGA = 2'b10,
    OP_NEGB = 2'b11
  } arith_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational W-bit ALU datapath: operand muxes, complement, adder, logic unit, flags
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int W = ALU_SEQ_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   alu_op,
  input  logic         arit,
  output logic [W-1:0] r,
  output logic         carry,
  output logic         ovf
);

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic [W:0]   sum;
  logic [W-1:0] lres;
  logic         c_msb;

  // Subtract and negate all reduce to x + ~y + 1 with x forced to zero for negation
  always_comb begin
    x   = a;
    y   = b;
    cin = 1'b0;
    case (alu_op)
      OP_ADD:  begin x = a;     y = b;  cin = 1'b0; end
      OP_SUB:  begin x = a;     y = ~b; cin = 1'b1; end
      OP_NEGA: begin x = '0;    y = ~a; cin = 1'b1; end
      default: begin x = '0;    y = ~b; cin = 1'b1; end
    endcase
  end

  always_comb begin
    lres = '0;
    case (alu_op)
      OP_AND:  lres = a & b;
      OP_OR:   lres = a | b;
      OP_XOR:  lres = a ^ b;
      default: lres = ~a;
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

  // Carry into the MSB recovered from the MSB sum bit
  assign c_msb = sum[W-1] ^ x[W-1] ^ y[W-1];

  assign r     = arit ? sum[W-1:0] : lres;
  assign carry = arit & sum[W];
  assign ovf   = arit & (c_msb ^ sum[W]);

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequenced ALU with registered result/flags; ALU_SEQ_MUL_EN adds a W-cycle shift-add multiply
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = ALU_SEQ_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [1:0]   ALUOp,
  input  logic         arit,
  input  logic         mul,
  output logic [W-1:0] R,
  output logic         zero,
  output logic         carry,
  output logic         sign,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [1:0]   op_q;
  logic         arit_q;
  logic         accept;
  logic         go_mul;
  logic         mul_last;
  logic [W-1:0] core_r;
  logic         core_c;
  logic         core_v;

  assign accept = (state == S_IDLE) && start;
  assign busy   = (state != S_IDLE);

  alu_core #(.W(W)) u_core (
    .a      (a_q),
    .b      (b_q),
    .alu_op (op_q),
    .arit   (arit_q),
    .r      (core_r),
    .carry  (core_c),
    .ovf    (core_v)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(W);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nx;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  assign go_mul   = mul;
  assign mul_last = (cnt == CW'(W-1));
  assign acc_nx   = mplier[0] ? (acc + mcand) : acc;

  // One partial product per MUL cycle; the final one is folded into the result load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, A};
      mplier <= B;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  logic unused_mul;

  assign unused_mul = mul;
  assign go_mul     = 1'b0;
  assign mul_last   = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = go_mul ? S_MUL : S_EXEC;
      S_EXEC:  state_nx = S_IDLE;
      S_MUL:   if (mul_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      arit_q <= 1'b0;
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B;
      op_q   <= ALUOp;
      arit_q <= arit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      R     <= '0;
      zero  <= 1'b1;
      carry <= 1'b0;
      sign  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_EXEC) begin
        R     <= core_r;
        zero  <= (core_r == '0);
        sign  <= core_r[W-1];
        carry <= core_c;
        ovf   <= core_v;
        done  <= 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      else if ((state == S_MUL) && mul_last) begin
        R     <= acc_nx[W-1:0];
        zero  <= (acc_nx[W-1:0] == '0);
        sign  <= acc_nx[W-1];
        carry <= |acc_nx[2*W-1:W];
        ovf   <= |acc_nx[2*W-1:W];
        done  <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (W=8); honours ALU_SEQ_MUL_EN
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [1:0] ALUOp = '0;
  logic       arit = 1'b0;
  logic       mul = 1'b0;
  logic [7:0] R;
  logic       zero, carry, sign, ovf, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .ALUOp (ALUOp),
    .arit  (arit),
    .mul   (mul),
    .R     (R),
    .zero  (zero),
    .carry (carry),
    .sign  (sign),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       s;
    logic       v;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       ar;
    logic       ml;
    res_t       exp;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation definitions
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] op, input logic ar, input logic ml);
    res_t o;
    int x, y, cin, u, sx, sy, ss, p;
    o = '0;
    if (ml && MUL_ON) begin
      p   = int'(a) * int'(b);
      o.r = p[7:0];
      o.c = (p > 255);
      o.v = (p > 255);
    end else if (!ar) begin
      case (op)
        2'd0:    o.r = a & b;
        2'd1:    o.r = a | b;
        2'd2:    o.r = a ^ b;
        default: o.r = ~a;
      endcase
    end else begin
      case (op)
        2'd0:    begin x = a; y = b;           cin = 0; end
        2'd1:    begin x = a; y = 255 - int'(b); cin = 1; end
        2'd2:    begin x = 0; y = 255 - int'(a); cin = 1; end
        default: begin x = 0; y = 255 - int'(b); cin = 1; end
      endcase
      u   = x + y + cin;
      o.r = u[7:0];
      o.c = (u > 255);
      sx  = (x > 127) ? x - 256 : x;
      sy  = (y > 127) ? y - 256 : y;
      ss  = sx + sy + cin;
      o.v = (ss > 127) || (ss < -128);
    end
    o.z = (o.r == 8'h00);
    o.s = o.r[7];
    return o;
  endfunction

  // Called #1 after a rising edge with the DUT idle or in its done cycle
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic ar, input logic ml, output res_t got, output int lat);
    A = a; B = b; ALUOp = op; arit = ar; mul = ml; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    got = '{r: R, z: zero, c: carry, s: sign, v: ovf};
  endtask

  vec_t tbl[12];
  res_t got;
  res_t exp;
  int   lat;
  int   ndone;

  initial begin
    tbl[0]  = '{8'hFF, 8'h01, 2'b00, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}, 1};
    tbl[1]  = '{8'h80, 8'h01, 2'b01, 1'b1, 1'b0, '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b1}, 1};
    tbl[2]  = '{8'h05, 8'h00, 2'b10, 1'b1, 1'b0, '{8'hFB, 1'b0, 1'b0, 1'b1, 1'b0}, 1};
    tbl[3]  = '{8'hF0, 8'h3C, 2'b10, 1'b0, 1'b0, '{8'hCC, 1'b0, 1'b0, 1'b1, 1'b0}, 1};
    tbl[4]  = '{8'hF0, 8'h0F, 2'b00, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}, 1};
    tbl[5]  = '{8'hF0, 8'h0F, 2'b01, 1'b0, 1'b0, '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0}, 1};
    tbl[6]  = '{8'h5A, 8'h00, 2'b11, 1'b0, 1'b0, '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0}, 1};
    tbl[7]  = '{8'h7F, 8'h01, 2'b00, 1'b1, 1'b0, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1}, 1};
    tbl[8]  = '{8'h33, 8'h00, 2'b11, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}, 1};
    tbl[9]  = '{8'h05, 8'h05, 2'b01, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}, 1};
`ifdef ALU_SEQ_MUL_EN
    tbl[10] = '{8'h10, 8'h11, 2'b00, 1'b0, 1'b1, '{8'h10, 1'b0, 1'b1, 1'b0, 1'b1}, 8};
`else
    tbl[10] = '{8'h10, 8'h11, 2'b00, 1'b0, 1'b1, '{8'h10, 1'b0, 1'b0, 1'b0, 1'b0}, 1};
`endif
    tbl[11] = '{8'h80, 8'h00, 2'b10, 1'b1, 1'b0, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1}, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_R", int'(R), 0);
    chk("reset_flags", int'({zero, carry, sign, ovf}), 4'b1000);
    chk("reset_busy_done", int'({busy, done}), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].ar, tbl[i].ml, got, lat);
      chk($sformatf("vec%0d_R", i), int'(got.r), int'(tbl[i].exp.r));
      chk($sformatf("vec%0d_zcsv", i), int'({got.z, got.c, got.s, got.v}),
          int'({tbl[i].exp.z, tbl[i].exp.c, tbl[i].exp.s, tbl[i].exp.v}));
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
    end

    // Result and flags hold while idle
    exp = got;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result", int'({R, zero, carry, sign, ovf}), int'(exp));
    chk("hold_no_done", int'(done), 0);

    // Inputs and start toggle while busy; result must reflect the first operands
    for (int rep = 0; rep < 2; rep++) begin
      exp = model(8'h0D, 8'h07, 2'b00, 1'b1, rep[0]);
      A = 8'h0D; B = 8'h07; ALUOp = 2'b00; arit = 1'b1; mul = rep[0]; start = 1'b1;
      @(posedge clk); #1;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
        if (busy) begin
          start = ~start;
          A = 8'($urandom);
          B = 8'($urandom);
          ALUOp = 2'($urandom);
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        if (done) begin
          ndone++;
          chk($sformatf("busy_ignore%0d_result", rep), int'({R, zero, carry, sign, ovf}), int'(exp));
        end
      end
      start = 1'b0;
      chk($sformatf("busy_ignore%0d_done_count", rep), ndone, 1);
    end

    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra, rb;
      logic [1:0] rop;
      logic       rar, rml;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 2'($urandom);
      rar = 1'($urandom);
      rml = ($urandom_range(0, 3) == 0);
      exp = model(ra, rb, rop, rar, rml);
      do_op(ra, rb, rop, rar, rml, got, lat);
      chk($sformatf("rand%0d_a%0h_b%0h_op%0d_ar%0d_ml%0d", i, ra, rb, rop, rar, rml),
          int'(got), int'(exp));
      chk($sformatf("rand%0d_latency", i), lat, (rml && MUL_ON) ? 8 : 1);
    end

    // Reset while an operation is in flight (mid-multiply when enabled)
    do_op(8'hF0, 8'h0F, 2'b01, 1'b0, 1'b0, got, lat);
    A = 8'h0F; B = 8'h0F; ALUOp = 2'b00; arit = 1'b0; mul = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (MUL_ON ? 3 : 0) begin
      @(posedge clk); #1;
    end
    chk("abort_busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("abort_reset_R", int'(R), 0);
    chk("abort_reset_flags", int'({zero, carry, sign, ovf}), 4'b1000);
    chk("abort_reset_busy_done", int'({busy, done}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_R_kept_reset", int'(R), 0);
    exp = model(8'h06, 8'h07, 2'b00, 1'b0, 1'b1);
    do_op(8'h06, 8'h07, 2'b00, 1'b0, 1'b1, got, lat);
    chk("after_reset_result", int'(got), int'(exp));
    chk("after_reset_latency", lat, MUL_ON ? 8 : 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
